uart_sample_loader: RTL and testbench

- Downstream consumer of the UART receiver's byte stream.
- Packs received bytes into complex fixed-point samples (real, imag) and writes them sequentially into the FFT sample memory.
- After N_POINTS samples, pulses a frame-done strobe to start the in-place FFT, then holds off until the FFT reports completion.
- Discards a partial sample if an inter-byte gap exceeds a timeout, so a dropped byte cannot skew the framing.

---
 rtl/uart_sample_loader.sv | 145 ++++++++++++++
 tb/tb_uart_sample_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_sample_loader.sv
// UART byte stream to FFT sample memory loader.
// Packs little-endian bytes into {imag, real} samples and writes them sequentially.
// After a full frame it strobes frame-done and waits for the FFT to finish.
// An inter-byte gap inside a sample discards the partial sample.
module uart_sample_loader #(
   parameter int unsigned N_POINTS     = 64,
   parameter int unsigned ADDR_W       = 6,
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned TIMEOUT_CLKS = 1740
) (
   input  logic                  i_Clock,
   input  logic                  i_Reset,
   input  logic                  i_Rx_DV,
   input  logic [7:0]            i_Rx_Byte,
   input  logic                  i_Fft_Done,
   output logic                  o_Wr_En,
   output logic [ADDR_W-1:0]     o_Wr_Addr,
   output logic [2*DATA_W-1:0]   o_Wr_Data,
   output logic                  o_Frame_Done,
   output logic                  o_Busy,
   output logic                  o_Overrun,
   output logic                  o_Resync
);

   localparam int unsigned TmoW     = ($clog2(TIMEOUT_CLKS) > 16) ? $clog2(TIMEOUT_CLKS) : 16;
   localparam int unsigned WordW    = 2 * DATA_W;
   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N_POINTS - 1);
   // Last idle count before the counter would reach TIMEOUT_CLKS-1.
   localparam logic [TmoW-1:0]   TmoLast  = TmoW'(TIMEOUT_CLKS - 2);

   typedef enum logic [1:0] {StCollect, StDone, StWaitFft} state_e;

   state_e              state_q, state_d;
   logic [1:0]          byte_cnt_q, byte_cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [TmoW-1:0]     tmo_q, tmo_d;
   logic [WordW-1:0]    asm_q, asm_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [WordW-1:0]    wr_data_q, wr_data_d;
   logic                overrun_q, overrun_d;
   logic                resync_q, resync_d;

   logic collect, accept, last_byte, timeout;

   // State register.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q <= StCollect;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: frame ends in the cycle the last-address write is on the bus.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StCollect: if (wr_en_q && (wr_addr_q == LastAddr)) state_d = StDone;
         StDone:    state_d = StWaitFft;
         StWaitFft: if (i_Fft_Done) state_d = StCollect;
         default:   state_d = StCollect;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      o_Frame_Done = (state_q == StDone);
      o_Busy       = (state_q == StWaitFft);
   end

   // Byte assembly, timeout and write-port next-state.
   always_comb begin
      collect   = (state_q == StCollect);
      accept    = collect && i_Rx_DV;
      last_byte = accept && (byte_cnt_q == 2'd3);
      // A byte arriving on the final idle cycle wins over the timeout.
      timeout   = collect && !i_Rx_DV && (byte_cnt_q != 2'd0) && (tmo_q == TmoLast);

      byte_cnt_d = byte_cnt_q;
      tmo_d      = tmo_q;
      asm_d      = asm_q;
      addr_d     = addr_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      overrun_d  = overrun_q | ((state_q == StWaitFft) && i_Rx_DV);
      resync_d   = timeout;

      if (accept) begin
         byte_cnt_d = byte_cnt_q + 2'd1;
         tmo_d      = '0;
         case (byte_cnt_q)
            2'd0:    asm_d[7:0]   = i_Rx_Byte;
            2'd1:    asm_d[15:8]  = i_Rx_Byte;
            2'd2:    asm_d[23:16] = i_Rx_Byte;
            default: asm_d[31:24] = i_Rx_Byte;
         endcase
      end else if (timeout) begin
         byte_cnt_d = 2'd0;
         tmo_d      = '0;
      end else if (collect && (byte_cnt_q != 2'd0)) begin
         tmo_d = tmo_q + TmoW'(1);
      end

      if (last_byte) begin
         wr_en_d   = 1'b1;
         wr_addr_d = addr_q;
         wr_data_d = asm_d;
         addr_d    = addr_q + ADDR_W'(1);
      end
   end

   // Datapath registers.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         byte_cnt_q <= 2'd0;
         addr_q     <= '0;
         tmo_q      <= '0;
         asm_q      <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         overrun_q  <= 1'b0;
         resync_q   <= 1'b0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         addr_q     <= addr_d;
         tmo_q      <= tmo_d;
         asm_q      <= asm_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         overrun_q  <= overrun_d;
         resync_q   <= resync_d;
      end
   end

   assign o_Wr_En   = wr_en_q;
   assign o_Wr_Addr = wr_addr_q;
   assign o_Wr_Data = wr_data_q;
   assign o_Overrun = overrun_q;
   assign o_Resync  = resync_q;

endmodule

// File: tb/tb_uart_sample_loader.sv
// Bench for uart_sample_loader: 4-point frames, 10-clock inter-byte timeout.
module tb_uart_sample_loader;

   localparam int unsigned NPts = 4;
   localparam int unsigned AW   = 2;
   localparam int unsigned Tmo  = 10;

   logic          clk = 1'b0;
   logic          rst, dv, fft;
   logic [7:0]    rx;
   logic          wr_en, frame_done, busy, overrun, resync;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_data;

   uart_sample_loader #(
      .N_POINTS    (NPts),
      .ADDR_W      (AW),
      .DATA_W      (16),
      .TIMEOUT_CLKS(Tmo)
   ) dut (
      .i_Clock     (clk),
      .i_Reset     (rst),
      .i_Rx_DV     (dv),
      .i_Rx_Byte   (rx),
      .i_Fft_Done  (fft),
      .o_Wr_En     (wr_en),
      .o_Wr_Addr   (wr_addr),
      .o_Wr_Data   (wr_data),
      .o_Frame_Done(frame_done),
      .o_Busy      (busy),
      .o_Overrun   (overrun),
      .o_Resync    (resync)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]    b;
      int            gap;
      bit            wr;
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } vec_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      int            when;
   } wr_t;

   vec_t tbl[16];
   wr_t  exp_q[$];
   wr_t  mon_e;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   neg_cnt = 0;
   int   fd_cnt = 0;
   int   rs_cnt = 0;
   int   rs_last = -1;
   int   rs0, base;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) sync();
   endtask

   // Drive one byte for one clock; returns just after the sampling edge.
   task automatic send(input logic [7:0] b);
      dv = 1'b1;
      rx = b;
      sync();
      dv = 1'b0;
      rx = 8'h00;
   endtask

   // Called right after the edge that took the 4th byte: write due on the next negedge.
   task automatic push(input logic [AW-1:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      e.when = neg_cnt + 1;
      exp_q.push_back(e);
   endtask

   task automatic send_sample(input logic [31:0] w, input logic [AW-1:0] a, input int gap);
      for (int k = 0; k < 4; k++) begin
         idle(gap);
         send(w[8*k +: 8]);
      end
      push(a, w);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_wr_en"}, wr_en, 0);
      chk({tag, "_wr_addr"}, wr_addr, 0);
      chk({tag, "_wr_data"}, wr_data, 0);
      chk({tag, "_frame_done"}, frame_done, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_overrun"}, overrun, 0);
      chk({tag, "_resync"}, resync, 0);
   endtask

   // Called right after the edge that took the last byte of a frame.
   task automatic frame_end_checks(input string tag);
      @(negedge clk);
      chk({tag, "_fd_not_with_write"}, frame_done, 0);
      @(negedge clk);
      chk({tag, "_frame_done"}, frame_done, 1);
      chk({tag, "_busy_in_done"}, busy, 0);
      @(negedge clk);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_fd_one_cycle"}, frame_done, 0);
      sync();
   endtask

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin
      neg_cnt++;
      if (wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_write: addr %0d data 0x%0h, none expected", wr_addr, wr_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", wr_addr, mon_e.addr);
            chk("wr_data", wr_data, mon_e.data);
            chk("wr_latency", neg_cnt, mon_e.when);
         end
      end
      if (frame_done === 1'b1) fd_cnt++;
      if (resync === 1'b1) begin
         rs_cnt++;
         rs_last = neg_cnt;
      end
   end

   initial begin
      rst = 1'b1;
      dv  = 1'b0;
      fft = 1'b0;
      rx  = 8'h00;

      for (int i = 0; i < 16; i++) begin
         tbl[i].b    = 8'(i + 1);
         tbl[i].gap  = i % 3;
         tbl[i].wr   = 1'b0;
         tbl[i].addr = '0;
         tbl[i].data = '0;
      end
      tbl[3].wr  = 1'b1;  tbl[3].addr  = 2'd0;  tbl[3].data  = 32'h04030201;
      tbl[7].wr  = 1'b1;  tbl[7].addr  = 2'd1;  tbl[7].data  = 32'h08070605;
      tbl[11].wr = 1'b1;  tbl[11].addr = 2'd2;  tbl[11].data = 32'h0C0B0A09;
      tbl[15].wr = 1'b1;  tbl[15].addr = 2'd3;  tbl[15].data = 32'h100F0E0D;

      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_checks("reset");
      sync();
      rst = 1'b0;

      // Full frame from the vector table, including back-to-back bytes on write cycles.
      for (int i = 0; i < 16; i++) begin
         idle(tbl[i].gap);
         send(tbl[i].b);
         if (tbl[i].wr) push(tbl[i].addr, tbl[i].data);
      end
      frame_end_checks("frame1");

      // Byte during FFT wait is dropped and flagged.
      send(8'hAA);
      idle(2);
      @(negedge clk);
      chk("overrun_set", overrun, 1);
      chk("busy_hold", busy, 1);
      sync();
      fft = 1'b1;
      sync();
      fft = 1'b0;
      @(negedge clk);
      chk("busy_after_fft", busy, 0);
      sync();
      send_sample(32'h44332211, 2'd0, 1);

      // Partial sample discarded after the inter-byte timeout.
      rs0 = rs_cnt;
      send(8'h12);
      send(8'h34);
      base = neg_cnt;
      idle(Tmo);
      chk("resync_count", rs_cnt - rs0, 1);
      chk("resync_time", rs_last, base + 10);
      send_sample(32'hDEADBEEF, 2'd1, 1);

      // 4th byte on the last idle cycle before timeout wins.
      rs0 = rs_cnt;
      send(8'h5A);
      send(8'h6B);
      send(8'h7C);
      idle(8);
      send(8'h8D);
      push(2'd2, 32'h8D7C6B5A);
      idle(12);
      chk("no_resync_boundary", rs_cnt - rs0, 0);

      // Finish frame 2, then byte and FFT done in the same cycle.
      send_sample(32'h0BADF00D, 2'd3, 0);
      frame_end_checks("frame2");
      dv  = 1'b1;
      rx  = 8'h99;
      fft = 1'b1;
      sync();
      dv  = 1'b0;
      fft = 1'b0;
      @(negedge clk);
      chk("same_cycle_busy", busy, 0);
      chk("same_cycle_overrun", overrun, 1);
      sync();
      send_sample(32'hCAFE1234, 2'd0, 2);
      send_sample(32'h55AA33CC, 2'd1, 0);
      send(8'h77);

      // Mid-frame reset discards everything and clears the sticky flag.
      rst = 1'b1;
      sync();
      @(negedge clk);
      reset_checks("midreset");
      sync();
      rst = 1'b0;
      send(8'h21);
      fft = 1'b1;  // ignored outside the FFT wait
      sync();
      fft = 1'b0;
      send(8'h43);
      send(8'h65);
      send(8'h87);
      push(2'd0, 32'h87654321);
      idle(4);
      @(negedge clk);
      chk("overrun_stays_clear", overrun, 0);
      chk("busy_after_stray_fft", busy, 0);

      idle(5);
      chk("pending_writes", exp_q.size(), 0);
      chk("frame_done_pulses", fd_cnt, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
